sdram_arbit: RTL

SDRAM_ARBIT -- requirements
Module: sdram_arbit

---
 rtl/sdram_param.sv | 36 +++
 rtl/sdram_arbit_if.sv | 55 +++++
 rtl/sdram_wdog.sv | 42 ++++
 rtl/sdram_arbit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sdram_param.sv
// Shared SDRAM command codes, arbiter state encodings and the command-bus payload type.
package sdram_param;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned WDOG_W = 10;

  // {CS_n, RAS_n, CAS_n, WE_n}
  typedef enum logic [CMD_W-1:0] {
    CMD_MRS = 4'b0000,
    CMD_ARF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] a_addr;
    logic [BANK_W-1:0] bank;
  } sdram_bus_t;

  localparam sdram_bus_t BUS_NOP = '{cmd: CMD_NOP, a_addr: '0, bank: '0};

endpackage

// File: rtl/sdram_arbit_if.sv
// Requester, init-sequencer and SDRAM-pin signals of the arbiter; master is the arbiter side.
interface sdram_arbit_if;
  import sdram_param::*;

  logic              INIT_DONE;
  logic [CMD_W-1:0]  INIT_CMD;
  logic [ADDR_W-1:0] INIT_A_ADDR;
  logic [BANK_W-1:0] INIT_BANK_ADDR;

  logic              ARF_req;
  logic              ARF_access;
  logic              REF_DONE;
  logic [CMD_W-1:0]  COMMAND_REF;
  logic [ADDR_W-1:0] ARF_A_ADDR;
  logic [BANK_W-1:0] ARF_BANK_ADDR;

  logic              WR_req;
  logic              WR_access;
  logic              WR_DONE;
  logic [CMD_W-1:0]  WR_CMD;
  logic [ADDR_W-1:0] WR_A_ADDR;
  logic [BANK_W-1:0] WR_BANK_ADDR;

  logic              RD_req;
  logic              RD_access;
  logic              RD_DONE;
  logic [CMD_W-1:0]  RD_CMD;
  logic [ADDR_W-1:0] RD_A_ADDR;
  logic [BANK_W-1:0] RD_BANK_ADDR;

  logic [CMD_W-1:0]  SDRAM_CMD;
  logic [ADDR_W-1:0] SDRAM_A_ADDR;
  logic [BANK_W-1:0] SDRAM_BANK_ADDR;
  logic [2:0]        ARB_STATE;
  logic              WDOG_ERR;

  modport master (
    input  INIT_DONE, INIT_CMD, INIT_A_ADDR, INIT_BANK_ADDR,
    input  ARF_req, REF_DONE, COMMAND_REF, ARF_A_ADDR, ARF_BANK_ADDR,
    input  WR_req, WR_DONE, WR_CMD, WR_A_ADDR, WR_BANK_ADDR,
    input  RD_req, RD_DONE, RD_CMD, RD_A_ADDR, RD_BANK_ADDR,
    output ARF_access, WR_access, RD_access,
    output SDRAM_CMD, SDRAM_A_ADDR, SDRAM_BANK_ADDR, ARB_STATE, WDOG_ERR
  );

  modport slave (
    output INIT_DONE, INIT_CMD, INIT_A_ADDR, INIT_BANK_ADDR,
    output ARF_req, REF_DONE, COMMAND_REF, ARF_A_ADDR, ARF_BANK_ADDR,
    output WR_req, WR_DONE, WR_CMD, WR_A_ADDR, WR_BANK_ADDR,
    output RD_req, RD_DONE, RD_CMD, RD_A_ADDR, RD_BANK_ADDR,
    input  ARF_access, WR_access, RD_access,
    input  SDRAM_CMD, SDRAM_A_ADDR, SDRAM_BANK_ADDR, ARB_STATE, WDOG_ERR
  );

endinterface

// File: rtl/sdram_wdog.sv
// Owner-hold watchdog: counts owned cycles since the last clear and flags the cycle
// in which the owned-cycle count reaches the limit.
module sdram_wdog #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         expire_q;
  logic         expire_d;

  // expire_q is precomputed so it is high in the cycle whose owned count equals the limit
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + W'(1);
    end
    expire_d = ((W+1)'(count_d) + (W+1)'(1)) >= (W+1)'(limit_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init pass-through, then refresh > write/read (alternating)
// with non-preemptive ownership, one-cycle grant pulses and a hold watchdog.
module sdram_arbit
  import sdram_param::*;
#(
  parameter logic [WDOG_W-1:0] WDOG_MAX = 10'd1023
) (
  input logic           Sys_clk,
  input logic           Rst,
  sdram_arbit_if.master bus_if
);

  arb_state_e state_q;
  logic       last_wr_q;
  logic       arf_acc_q;
  logic       wr_acc_q;
  logic       rd_acc_q;
  logic       wdog_err_q;
  sdram_bus_t sdram_q;

  sdram_bus_t init_bus_c;
  sdram_bus_t arf_bus_c;
  sdram_bus_t wr_bus_c;
  sdram_bus_t rd_bus_c;
  sdram_bus_t owner_bus_c;
  logic       owner_c;
  logic       done_c;
  logic       wdog_expire;

  assign init_bus_c = {bus_if.INIT_CMD, bus_if.INIT_A_ADDR, bus_if.INIT_BANK_ADDR};
  assign arf_bus_c  = {bus_if.COMMAND_REF, bus_if.ARF_A_ADDR, bus_if.ARF_BANK_ADDR};
  assign wr_bus_c   = {bus_if.WR_CMD, bus_if.WR_A_ADDR, bus_if.WR_BANK_ADDR};
  assign rd_bus_c   = {bus_if.RD_CMD, bus_if.RD_A_ADDR, bus_if.RD_BANK_ADDR};

  assign owner_c = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);

  // Only the current owner's bus and DONE are visible; everything else is ignored
  always_comb begin
    owner_bus_c = BUS_NOP;
    done_c      = 1'b0;
    case (state_q)
      ST_AREF: begin
        owner_bus_c = arf_bus_c;
        done_c      = bus_if.REF_DONE;
      end
      ST_WRITE: begin
        owner_bus_c = wr_bus_c;
        done_c      = bus_if.WR_DONE;
      end
      ST_READ: begin
        owner_bus_c = rd_bus_c;
        done_c      = bus_if.RD_DONE;
      end
      default: ;
    endcase
  end

  sdram_wdog #(
    .W (WDOG_W)
  ) u_wdog (
    .clk_i    (Sys_clk),
    .rst_i    (Rst),
    .clear_i  (!owner_c),
    .enable_i (owner_c),
    .limit_i  (WDOG_MAX),
    .expire_o (wdog_expire)
  );

  always_ff @(posedge Sys_clk) begin
    if (Rst) begin
      state_q    <= ST_INIT;
      last_wr_q  <= 1'b0;
      arf_acc_q  <= 1'b0;
      wr_acc_q   <= 1'b0;
      rd_acc_q   <= 1'b0;
      wdog_err_q <= 1'b0;
      sdram_q    <= BUS_NOP;
    end else begin
      arf_acc_q <= 1'b0;
      wr_acc_q  <= 1'b0;
      rd_acc_q  <= 1'b0;
      case (state_q)
        ST_INIT: begin
          sdram_q <= init_bus_c;
          if (bus_if.INIT_DONE) begin
            state_q <= ST_ARBIT;
          end
        end
        ST_ARBIT: begin
          sdram_q <= BUS_NOP;
          // Refresh first; on a write/read tie the side not granted last wins
          if (bus_if.ARF_req) begin
            state_q   <= ST_AREF;
            arf_acc_q <= 1'b1;
          end else if (bus_if.WR_req && (!bus_if.RD_req || !last_wr_q)) begin
            state_q   <= ST_WRITE;
            wr_acc_q  <= 1'b1;
            last_wr_q <= 1'b1;
          end else if (bus_if.RD_req) begin
            state_q   <= ST_READ;
            rd_acc_q  <= 1'b1;
            last_wr_q <= 1'b0;
          end
        end
        ST_AREF, ST_WRITE, ST_READ: begin
          if (done_c) begin
            state_q <= ST_ARBIT;
            sdram_q <= owner_bus_c;
          end else if (wdog_expire) begin
            state_q    <= ST_ARBIT;
            sdram_q    <= BUS_NOP;
            wdog_err_q <= 1'b1;
          end else begin
            sdram_q <= owner_bus_c;
          end
        end
        default: begin
          state_q <= ST_INIT;
          sdram_q <= BUS_NOP;
        end
      endcase
    end
  end

  assign bus_if.ARF_access      = arf_acc_q;
  assign bus_if.WR_access       = wr_acc_q;
  assign bus_if.RD_access       = rd_acc_q;
  assign bus_if.SDRAM_CMD       = sdram_q.cmd;
  assign bus_if.SDRAM_A_ADDR    = sdram_q.a_addr;
  assign bus_if.SDRAM_BANK_ADDR = sdram_q.bank;
  assign bus_if.ARB_STATE       = state_q;
  assign bus_if.WDOG_ERR        = wdog_err_q;

endmodule
